// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder.
// Holds the peripheral address map, the kseg mask used to fold cached and
// uncached MIPS-style segments onto the same physical RAM, and a byte-lane
// merge helper used by every byte-writable register.
package dmem_pkg;

  localparam logic [15:0] PERIPH_HI_DEF = 16'hBFAF;
  localparam logic [15:0] OFF_LED       = 16'hF000;
  localparam logic [15:0] OFF_SWITCH    = 16'hF004;
  localparam logic [15:0] OFF_TIMER     = 16'hE000;
  localparam logic [31:0] KSEG_MASK     = 32'h1FFF_FFFF;

  // Byte-lane merge: lane i of the result takes new_w when wen[i] is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (wen[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// sram_bank: 2^ADDR_W x 32 RAM with byte-lane writes and a read-first
// registered read port.
// Ports:
//   clk      - clock
//   rst_n    - async active-low reset (clears the read register only;
//              also blocks writes on any edge seen while asserted)
//   i_en     - access this cycle (already qualified by address decode)
//   i_wen    - byte-lane write enables, zero means read
//   i_addr   - word index
//   i_wdata  - write data
//   o_rdata  - pre-write word of the last access, held between accesses
module sram_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [3:0]        i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  // Contents are deliberately not reset. rst_n gating keeps an access that
  // collides with reset from landing in the array.
  always_ff @(posedge clk) begin
    if (rst_n && i_en) begin
      for (int i = 0; i < 4; i++)
        if (i_wen[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  // Non-blocking read of the same entry gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory responder with RAM, LED, switch
// and free-running timer peripherals.
// Ports:
//   clk, rst          - clock, async active-low reset
//   data_sram_en      - access request
//   data_sram_wen     - byte-lane write enables (0 = read)
//   data_sram_addr    - byte address
//   data_sram_wdata   - write data
//   data_sram_rdata   - registered read data, held while idle
//   switch            - asynchronous board switches
//   led               - LED register
//   addr_err          - sticky unmapped-access flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] PERIPH_HI = PERIPH_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        addr_err
);

  logic        w_periph, w_ram, w_hit_led, w_hit_sw, w_hit_tmr, w_bad;
  logic [31:0] w_prdata, w_bank_rdata;
  logic [31:0] r_timer, r_prdata;
  logic [15:0] r_led;
  logic [7:0]  r_sw_meta, r_sw_sync;
  logic        r_sel_ram, r_err;

  // Peripheral window wins; everything else folds through the kseg mask.
  assign w_periph  = (data_sram_addr[31:16] == PERIPH_HI);
  assign w_ram     = !w_periph &&
                     ((data_sram_addr & KSEG_MASK) < (32'd4 << ADDR_W));
  assign w_hit_led = data_sram_en && w_periph && (data_sram_addr[15:0] == OFF_LED);
  assign w_hit_sw  = data_sram_en && w_periph && (data_sram_addr[15:0] == OFF_SWITCH);
  assign w_hit_tmr = data_sram_en && w_periph && (data_sram_addr[15:0] == OFF_TIMER);
  assign w_bad     = data_sram_en && !w_ram && !w_hit_led && !w_hit_sw && !w_hit_tmr;

  sram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (data_sram_en && w_ram),
    .i_wen   (data_sram_wen),
    .i_addr  (data_sram_addr[ADDR_W+1:2]),
    .i_wdata (data_sram_wdata),
    .o_rdata (w_bank_rdata)
  );

  // Peripheral read mux; undefined offsets and unmapped space read zero.
  always_comb begin
    w_prdata = '0;
    if (w_hit_led)      w_prdata = {16'h0, r_led};
    else if (w_hit_sw)  w_prdata = {24'h0, r_sw_sync};
    else if (w_hit_tmr) w_prdata = r_timer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_ram <= 1'b0;
      r_prdata  <= '0;
      r_led     <= '0;
      r_timer   <= '0;
      r_err     <= 1'b0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      if (data_sram_en) begin
        r_sel_ram <= w_ram;
        r_prdata  <= w_prdata;
      end
      if (w_hit_led) begin
        if (data_sram_wen[0]) r_led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) r_led[15:8] <= data_sram_wdata[15:8];
      end
      // A timer write replaces that cycle's increment.
      if (w_hit_tmr && (data_sram_wen != 4'h0))
        r_timer <= lane_merge(r_timer, data_sram_wdata, data_sram_wen);
      else
        r_timer <= r_timer + 32'd1;
      r_err     <= r_err | w_bad;
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Response is held in whichever source served the last access.
  assign data_sram_rdata = r_sel_ram ? w_bank_rdata : r_prdata;
  assign led             = r_led;
  assign addr_err        = r_err;

endmodule
